sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 78 +++++++
 rtl/sram_arbiter.sv | 117 +++++++++++
 tb/tb_sram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-master SRAM arbiter: master IDs, the
// read-return owner tag, the lock-owner state encoding and the default
// address region.
package sram_arb_pkg;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    localparam logic [3:0] DEFAULT_REGION = 4'h4;

    // Tag registered at grant time so the read data returned one cycle later
    // can be routed to the master that issued the read.
    typedef struct packed {
        logic valid;
        logic id;
        logic oor;
    } owner_tag_t;

    // Lock ownership. Bit 0 carries the owning master ID when a lock is held.
    typedef enum logic [1:0] {
        LOCK_NONE = 2'b00,
        LOCK_M0   = 2'b10,
        LOCK_M1   = 2'b11
    } lock_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with bus locking. Grants are combinational;
// the round-robin pointer, lock owner and consecutive-lock counter are
// registered. A held lock is broken after MAX_LOCK consecutive grants when the
// other master is waiting.
module rr_arb2 import sram_arb_pkg::*; #(
    parameter int MAX_LOCK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt,
    output logic [1:0] lock_state
);

    localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MAX_LOCK - 1);

    lock_state_t   lock_q, lock_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic lock_on;
    logic owner;
    logic hold;

    assign lock_state = lock_q;

    // Grant selection plus next-state for pointer, lock owner and counter.
    always_comb begin
        gnt     = 2'b00;
        last_d  = last_q;
        lock_d  = LOCK_NONE;
        cnt_d   = '0;
        lock_on = (lock_q != LOCK_NONE);
        owner   = lock_q[0];
        // The owner keeps the bus unless it has used its full budget while
        // the other master waits.
        hold    = lock_on && req[owner] && !((cnt_q == LIMIT) && req[~owner]);

        if (hold) begin
            gnt[owner] = 1'b1;
        end else if (req == 2'b11) begin
            gnt[~last_q] = 1'b1;
        end else begin
            gnt = req;
        end

        // Nothing is granted while reset is asserted, whatever req says.
        if (!rst) begin
            gnt = 2'b00;
        end

        if (gnt != 2'b00) begin
            last_d = gnt[1];
            if (lock[gnt[1]]) begin
                lock_d = gnt[1] ? LOCK_M1 : LOCK_M0;
                if (hold) begin
                    cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CW'(1);
                end
            end
        end
    end

    // Arbitration state register; last resets to M1 so M0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q <= LOCK_NONE;
            last_q <= M_DMA;
            cnt_q  <= '0;
        end else begin
            lock_q <= lock_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port 512x32 SRAM between the CPU data port (M0) and a DMA
// master (M1). Every access is a single grant cycle; read data returns one
// cycle later and is steered by a registered owner tag. Accesses outside the
// configured 256 MB region never touch the SRAM and report an error.
//
// Handshake: mN_req is held with stable attributes until mN_gnt is seen high
// in the same cycle; the access is accepted on the rising edge where
// req && gnt. A read's mN_rvalid is high exactly one cycle after that edge.
module sram_arbiter import sram_arb_pkg::*; #(
    parameter int         AW       = 9,
    parameter logic [3:0] REGION   = DEFAULT_REGION,
    parameter int         MAX_LOCK = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [3:0]    m0_be,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic          m0_lock,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [3:0]    m1_be,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          m1_err,
    output logic          mem_cen,
    output logic          mem_wen,
    output logic [3:0]    mem_flag,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [1:0]    dbg_lock_state
);

    logic [1:0]  gnt;
    logic        any_gnt;
    logic        sel;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        in_range;
    logic        unused_addr_bits;

    owner_tag_t  tag_q;
    logic [1:0]  wr_err_q;

    rr_arb2 #(
        .MAX_LOCK   (MAX_LOCK)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        ({m1_req, m0_req}),
        .lock       ({m1_lock, m0_lock}),
        .gnt        (gnt),
        .lock_state (dbg_lock_state)
    );

    assign m0_gnt  = gnt[0];
    assign m1_gnt  = gnt[1];
    assign any_gnt = |gnt;
    assign sel     = gnt[1];

    // Byte offset and the address bits between the word index and the
    // region nibble do not select anything in the SRAM.
    assign unused_addr_bits = ^{sel_addr[1:0], sel_addr[27:AW+2]};

    // Steer the granted master's request onto the SRAM port.
    always_comb begin
        sel_we    = sel ? m1_we    : m0_we;
        sel_be    = sel ? m1_be    : m0_be;
        sel_addr  = sel ? m1_addr  : m0_addr;
        sel_wdata = sel ? m1_wdata : m0_wdata;
        in_range  = (sel_addr[31:28] == REGION);

        mem_cen   = any_gnt && in_range;
        mem_wen   = mem_cen && sel_we;
        mem_flag  = mem_wen ? sel_be : 4'b0000;
        mem_addr  = any_gnt ? sel_addr[AW+1:2] : '0;
        mem_wdata = mem_wen ? sel_wdata : 32'h0;
    end

    // Capture who owns next cycle's read data and which writes fell outside
    // the region.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q    <= '0;
            wr_err_q <= 2'b00;
        end else begin
            tag_q.valid <= any_gnt && !sel_we;
            tag_q.id    <= sel;
            tag_q.oor   <= !in_range;
            wr_err_q    <= (any_gnt && sel_we && !in_range) ? gnt : 2'b00;
        end
    end

    // Route returned SRAM data to the tagged owner; out-of-range reads give 0.
    always_comb begin
        m0_rvalid = tag_q.valid && (tag_q.id == M_CPU);
        m1_rvalid = tag_q.valid && (tag_q.id == M_DMA);
        m0_rdata  = (m0_rvalid && !tag_q.oor) ? mem_rdata : 32'h0;
        m1_rdata  = (m1_rvalid && !tag_q.oor) ? mem_rdata : 32'h0;
        m0_err    = (m0_rvalid && tag_q.oor) || wr_err_q[0];
        m1_err    = (m1_rvalid && tag_q.oor) || wr_err_q[1];
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 512x32 byte-writable SRAM.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid, m0_err;
    logic [3:0]  m0_be;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid, m1_err;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_cen, mem_wen;
    logic [3:0]  mem_flag;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [1:0]  dbg_lock_state;

    int n_cmp;
    int n_fail;

    logic [31:0] sram [512];
    int          sram_wr_cnt;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_flag(mem_flag),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_lock_state(dbg_lock_state)
    );

    // Clock and SRAM model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial sram_wr_cnt = 0;

    always @(posedge clk) begin
        if (mem_cen) begin
            if (mem_wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_flag[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
                sram_wr_cnt <= sram_wr_cnt + 1;
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    // Driver tasks
    task automatic set_m0(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic lock);
        m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata; m0_lock = lock;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic lock);
        m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
    endtask

    task automatic idle_all();
        set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b0;
        set_m0(1'b1, 1'b0, 4'hF, 32'h4000_0000, 32'h0, 1'b0);
        set_m1(1'b1, 1'b0, 4'hF, 32'h4000_0004, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
        n_cmp++; if (mem_cen !== 1'b0) begin n_fail++; $display("FAIL rst_cen: got %b want 0", mem_cen); end
        n_cmp++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); end
        n_cmp++; if ({m0_rdata, m1_rdata} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", {m0_rdata, m1_rdata}); end
        next_cycle();
        rst = 1'b1;
        idle_all();
    endtask

    task automatic test_write_read();
        next_cycle();
        set_m0(1'b1, 1'b1, 4'hF, 32'h4000_0010, 32'h1122_3344, 1'b0);
        @(negedge clk);
        n_cmp++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b want 1", m0_gnt); end
        n_cmp++; if ({mem_cen, mem_wen, mem_flag} !== 6'b11_1111) begin n_fail++; $display("FAIL wr_full_ctl: got %b want 111111", {mem_cen, mem_wen, mem_flag}); end

        next_cycle();
        set_m0(1'b1, 1'b1, 4'b0101, 32'h4000_0010, 32'hAABB_CCDD, 1'b0);
        @(negedge clk);
        n_cmp++; if (mem_addr !== 9'd4) begin n_fail++; $display("FAIL wr_addr: got %0d want 4", mem_addr); end
        n_cmp++; if (mem_flag !== 4'b0101) begin n_fail++; $display("FAIL wr_flag: got %b want 0101", mem_flag); end
        n_cmp++; if (mem_wdata !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL wr_wdata: got %h want aabbccdd", mem_wdata); end
        n_cmp++; if (m0_err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", m0_err); end

        next_cycle();
        set_m0(1'b1, 1'b1, 4'b0000, 32'h4000_0010, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        n_cmp++; if ({mem_cen, mem_wen, mem_flag} !== 6'b11_0000) begin n_fail++; $display("FAIL wr_be0_ctl: got %b want 110000", {mem_cen, mem_wen, mem_flag}); end

        next_cycle();
        set_m0(1'b1, 1'b0, 4'hF, 32'h4000_0010, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++; if ({m0_gnt, mem_cen, mem_wen, mem_flag} !== 7'b110_0000) begin n_fail++; $display("FAIL rd_ctl: got %b want 1100000", {m0_gnt, mem_cen, mem_wen, mem_flag}); end
        n_cmp++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_early_rvalid: got %b want 0", m0_rvalid); end

        next_cycle();
        idle_all();
        @(negedge clk);
        n_cmp++; if ({m0_rvalid, m1_rvalid, m0_err} !== 3'b100) begin n_fail++; $display("FAIL rd_rvalid: got %b want 100", {m0_rvalid, m1_rvalid, m0_err}); end
        n_cmp++; if (m0_rdata !== 32'h11BB_33DD) begin n_fail++; $display("FAIL rd_merge: got %h want 11bb33dd", m0_rdata); end

        next_cycle();
        @(negedge clk);
        n_cmp++; if ({m0_rvalid, m0_rdata} !== 33'h0) begin n_fail++; $display("FAIL rd_after: got %b/%h want 0/0", m0_rvalid, m0_rdata); end
    endtask

    task automatic test_alternate();
        // Preload word 8 from M0 and word 9 from M1.
        next_cycle();
        set_m0(1'b1, 1'b1, 4'hF, 32'h4000_0020, 32'hC0C0_0008, 1'b0);
        next_cycle();
        set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        set_m1(1'b1, 1'b1, 4'hF, 32'h4000_0024, 32'hD1D1_0009, 1'b0);
        @(negedge clk);
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_fail++; $display("FAIL alt_preload_gnt: got %b want 01", {m0_gnt, m1_gnt}); end
        next_cycle();
        idle_all();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            next_cycle();
            if (i < 7) begin
                set_m0(1'b1, 1'b0, 4'hF, 32'h4000_0020, 32'h0, 1'b0);
                set_m1(1'b1, 1'b0, 4'hF, 32'h4000_0024, 32'h0, 1'b0);
            end else begin
                idle_all();
            end
            @(negedge clk);
            if (i < 7) begin
                n_cmp++; if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL alt_gnt[%0d]: got %b want %b", i, {m0_gnt, m1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01); end
            end
            if (i > 0) begin
                n_cmp++; if ({m0_rvalid, m1_rvalid} !== (((i - 1) % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL alt_rvalid[%0d]: got %b want %b", i, {m0_rvalid, m1_rvalid}, ((i - 1) % 2 == 0) ? 2'b10 : 2'b01); end
                n_cmp++; if (m0_rdata !== (((i - 1) % 2 == 0) ? 32'hC0C0_0008 : 32'h0)) begin n_fail++; $display("FAIL alt_rdata0[%0d]: got %h", i, m0_rdata); end
                n_cmp++; if (m1_rdata !== (((i - 1) % 2 == 1) ? 32'hD1D1_0009 : 32'h0)) begin n_fail++; $display("FAIL alt_rdata1[%0d]: got %h", i, m1_rdata); end
            end
        end
    endtask

    task automatic test_lock();
        logic exp0;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            set_m0(1'b1, 1'b0, 4'hF, 32'h4000_0020, 32'h0, 1'b0);
            set_m1(1'b1, 1'b0, 4'hF, 32'h4000_0024, 32'h0, 1'b1);
            @(negedge clk);
            exp0 = (i == 16) || (i == 33);
            n_cmp++; if ({m0_gnt, m1_gnt} !== {exp0, !exp0}) begin n_fail++; $display("FAIL lock_gnt[%0d]: got %b want %b", i, {m0_gnt, m1_gnt}, {exp0, !exp0}); end
            if (i == 5) begin
                n_cmp++; if (dbg_lock_state !== 2'b11) begin n_fail++; $display("FAIL lock_state_held: got %b want 11", dbg_lock_state); end
            end
            if (i == 17) begin
                n_cmp++; if (dbg_lock_state !== 2'b00) begin n_fail++; $display("FAIL lock_state_broken: got %b want 00", dbg_lock_state); end
            end
        end
        next_cycle();
        idle_all();
        @(negedge clk);
        n_cmp++; if ({m1_rvalid, m1_rdata} !== {1'b1, 32'hD1D1_0009}) begin n_fail++; $display("FAIL lock_last_rd: got %b/%h want 1/d1d10009", m1_rvalid, m1_rdata); end
    endtask

    task automatic test_out_of_range();
        int wr_before;
        next_cycle();
        set_m0(1'b1, 1'b0, 4'hF, 32'hE000_0000, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++; if ({m0_gnt, mem_cen} !== 2'b10) begin n_fail++; $display("FAIL oor_rd_ctl: got %b want 10", {m0_gnt, mem_cen}); end

        next_cycle();
        wr_before = sram_wr_cnt;
        set_m0(1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        n_cmp++; if ({m0_rvalid, m0_err} !== 2'b11) begin n_fail++; $display("FAIL oor_rd_err: got %b want 11", {m0_rvalid, m0_err}); end
        n_cmp++; if (m0_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data: got %h want 0", m0_rdata); end
        n_cmp++; if ({m0_gnt, mem_cen, mem_wen} !== 3'b100) begin n_fail++; $display("FAIL oor_wr_ctl: got %b want 100", {m0_gnt, mem_cen, mem_wen}); end

        next_cycle();
        idle_all();
        @(negedge clk);
        n_cmp++; if ({m0_rvalid, m0_err} !== 2'b01) begin n_fail++; $display("FAIL oor_wr_err: got %b want 01", {m0_rvalid, m0_err}); end
        n_cmp++; if (sram_wr_cnt !== wr_before) begin n_fail++; $display("FAIL oor_wr_dropped: got %0d writes want %0d", sram_wr_cnt, wr_before); end

        next_cycle();
        @(negedge clk);
        n_cmp++; if (m0_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse: got %b want 0", m0_err); end
    endtask

    task automatic test_reset_mid_read();
        next_cycle();
        set_m0(1'b1, 1'b0, 4'hF, 32'h4000_0020, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt: got %b want 1", m0_gnt); end
        @(posedge clk);
        rst = 1'b0;
        set_m1(1'b1, 1'b0, 4'hF, 32'h4000_0024, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL mid_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
        n_cmp++; if ({m0_gnt, m1_gnt, mem_cen} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_comb: got %b want 000", {m0_gnt, m1_gnt, mem_cen}); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if ({m0_rvalid, m0_rdata} !== 33'h0) begin n_fail++; $display("FAIL mid_rst_hold: got %b/%h want 0/0", m0_rvalid, m0_rdata); end

        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL post_rst_tie: got %b want 10", {m0_gnt, m1_gnt}); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_fail++; $display("FAIL post_rst_rr: got %b want 01", {m0_gnt, m1_gnt}); end
        n_cmp++; if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hC0C0_0008}) begin n_fail++; $display("FAIL post_rst_rd0: got %b/%h want 1/c0c00008", m0_rvalid, m0_rdata); end
        next_cycle();
        idle_all();
        @(negedge clk);
        n_cmp++; if ({m1_rvalid, m1_rdata} !== {1'b1, 32'hD1D1_0009}) begin n_fail++; $display("FAIL post_rst_rd1: got %b/%h want 1/d1d10009", m1_rvalid, m1_rdata); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            @(negedge clk);
            n_cmp++; if ({m0_gnt, m1_gnt, mem_cen} !== 3'b000) begin n_fail++; $display("FAIL idle[%0d]: got %b want 000", i, {m0_gnt, m1_gnt, mem_cen}); end
        end
        next_cycle();
        set_m0(1'b1, 1'b0, 4'hF, 32'h4000_0020, 32'h0, 1'b0);
        set_m1(1'b1, 1'b0, 4'hF, 32'h4000_0024, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL idle_tie_a: got %b want 10", {m0_gnt, m1_gnt}); end
        next_cycle();
        idle_all();
        for (int i = 0; i < 3; i++) next_cycle();
        set_m0(1'b1, 1'b0, 4'hF, 32'h4000_0020, 32'h0, 1'b0);
        set_m1(1'b1, 1'b0, 4'hF, 32'h4000_0024, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_fail++; $display("FAIL idle_tie_b: got %b want 01", {m0_gnt, m1_gnt}); end
        next_cycle();
        idle_all();
    endtask

    // Main sequence and report
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        idle_all();
        test_reset();
        test_write_read();
        test_alternate();
        test_lock();
        test_out_of_range();
        test_reset_mid_read();
        test_idle();
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
